// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package inst_fetch_buffer_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int PC_W      = 32;
    localparam int INST_W    = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    // One buffered fetch return: address, word, address-error flag, delay-slot marker.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              adel;
        logic              ds;
    } fb_entry_t;

    localparam int ENTRY_W = $bits(fb_entry_t);

    // Build an entry from its fields.
    function automatic fb_entry_t make_entry(input logic [PC_W-1:0] pc,
                                             input logic [INST_W-1:0] inst,
                                             input logic adel,
                                             input logic ds);
        fb_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        e.adel = adel;
        e.ds   = ds;
        return e;
    endfunction

    // Return a copy of an entry with its delay-slot marker set.
    function automatic fb_entry_t mark_ds(input fb_entry_t e);
        fb_entry_t m;
        m    = e;
        m.ds = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/inst_fetch_buffer_ram.sv
// Entry storage: DEPTH x fb_entry_t registers, one write port and two
// combinational read ports (head and head+1).
module fetch_buf_ram
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  fb_entry_t       wdata,
    input  logic [AW-1:0]   raddr0,
    input  logic [AW-1:0]   raddr1,
    output fb_entry_t       rdata0,
    output fb_entry_t       rdata1
);

    fb_entry_t mem_r [DEPTH];

    // Storage array; cleared on reset so no stale entry can ever leak out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_r[raddr0];
    assign rdata1 = mem_r[raddr1];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch FIFO between fetch and decode. Handles decode-resolved
// redirects (keeping only the delay slot) and exception flushes.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush_i,
    input  logic              redirect_i,
    input  logic              stallD,
    input  logic              push_valid_i,
    input  logic [PC_W-1:0]   push_pc_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic              push_adel_i,
    output logic              push_ready_o,
    output logic              validD,
    output logic [INST_W-1:0] instrD,
    output logic [PC_W-1:0]   pcD,
    output logic              adelD,
    output logic              is_in_delayslotD,
    output logic [AW:0]       count_o
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_TWO  = AW'(2);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_n, wr_ptr_n;
    logic [AW:0]   count_r, count_n;
    logic          ds_wait_r, ds_wait_n;

    logic          acc_s, deq_s, redir_s;
    logic          we_s;
    logic [AW-1:0] waddr_s;
    fb_entry_t     wdata_s, head_s, next_s;

    fetch_buf_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (we_s),
        .waddr  (waddr_s),
        .wdata  (wdata_s),
        .raddr0 (rd_ptr_r),
        .raddr1 (rd_ptr_r + PTR_ONE),
        .rdata0 (head_s),
        .rdata1 (next_s)
    );

    assign validD       = (count_r != CNT_ZERO);
    assign push_ready_o = (count_r < CNT_FULL);
    assign acc_s        = push_valid_i & push_ready_o & ~flush_i;
    assign deq_s        = validD & ~stallD;
    // A redirect only means something when decode actually consumes the branch.
    assign redir_s      = redirect_i & deq_s & ~flush_i;

    // Head outputs read as a nop when the buffer is empty.
    assign instrD           = validD ? head_s.inst : NOP_INST;
    assign pcD              = validD ? head_s.pc   : {PC_W{1'b0}};
    assign adelD            = validD & head_s.adel;
    assign is_in_delayslotD = validD & head_s.ds;
    assign count_o          = count_r;

    // Next-state: flush beats redirect, redirect beats normal push/pop.
    always_comb begin
        rd_ptr_n  = rd_ptr_r;
        wr_ptr_n  = wr_ptr_r;
        count_n   = count_r;
        ds_wait_n = ds_wait_r;
        we_s      = 1'b0;
        waddr_s   = wr_ptr_r;
        wdata_s   = make_entry(push_pc_i, push_inst_i, push_adel_i, ds_wait_r);
        if (flush_i) begin
            rd_ptr_n  = PTR_ZERO;
            wr_ptr_n  = PTR_ZERO;
            count_n   = CNT_ZERO;
            ds_wait_n = 1'b0;
        end else if (redir_s) begin
            if (count_r >= CNT_TWO) begin
                // Delay slot already buffered: rewrite it in place with ds set,
                // drop everything behind it and any push this cycle.
                we_s      = 1'b1;
                waddr_s   = rd_ptr_r + PTR_ONE;
                wdata_s   = mark_ds(next_s);
                rd_ptr_n  = rd_ptr_r + PTR_ONE;
                wr_ptr_n  = rd_ptr_r + PTR_TWO;
                count_n   = CNT_ONE;
                ds_wait_n = 1'b0;
            end else if (acc_s) begin
                // Delay slot arrives in the same cycle as the branch leaves.
                we_s      = 1'b1;
                wdata_s   = make_entry(push_pc_i, push_inst_i, push_adel_i, 1'b1);
                rd_ptr_n  = wr_ptr_r;
                wr_ptr_n  = wr_ptr_r + PTR_ONE;
                count_n   = CNT_ONE;
                ds_wait_n = 1'b0;
            end else begin
                // Delay slot not fetched yet: mark the next accepted push.
                rd_ptr_n  = rd_ptr_r + PTR_ONE;
                count_n   = CNT_ZERO;
                ds_wait_n = 1'b1;
            end
        end else begin
            if (acc_s) begin
                we_s      = 1'b1;
                wr_ptr_n  = wr_ptr_r + PTR_ONE;
                ds_wait_n = 1'b0;
            end else begin
                wr_ptr_n  = wr_ptr_r;
            end
            if (deq_s) begin
                rd_ptr_n = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_n = rd_ptr_r;
            end
            count_n = count_r + {{AW{1'b0}}, acc_s} - {{AW{1'b0}}, deq_s};
        end
    end

    // Pointer, occupancy and pending-delay-slot state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_r  <= PTR_ZERO;
            wr_ptr_r  <= PTR_ZERO;
            count_r   <= CNT_ZERO;
            ds_wait_r <= 1'b0;
        end else begin
            rd_ptr_r  <= rd_ptr_n;
            wr_ptr_r  <= wr_ptr_n;
            count_r   <= count_n;
            ds_wait_r <= ds_wait_n;
        end
    end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Instruction prefetch FIFO between the fetch stage and the main decoder; it supplies instrD and pcD to decode.
- Decouples fetch-side returns from decode stalls.
- On a branch redirect resolved in decode, keeps only the delay-slot instruction. On an exception flush, clears everything.
- Carries the fetch address-error flag and a delay-slot marker for CP0 EPC handling.

Parameters:
DEPTH, 4, number of entries; must be a power of 2 and at least 2
AW, 2, pointer width, equal to log2(DEPTH)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush_i  in  1  exception/eret flush; discards all contents
redirect_i  in  1  branch/jump taken, resolved in decode this cycle
stallD  in  1  decode stall; head entry is not consumed
push_valid_i  in  1  fetch has an instruction this cycle
push_pc_i  in  32  PC of the pushed instruction
push_inst_i  in  32  pushed instruction word
push_adel_i  in  1  fetch address error on this PC
push_ready_o  out  1  buffer can accept a push
validD  out  1  head entry valid
instrD  out  32  head instruction; 32'h0 (nop) when empty
pcD  out  32  head PC; 0 when empty
adelD  out  1  head address-error flag; 0 when empty
is_in_delayslotD  out  1  head entry is a delay slot kept by a redirect
count_o  out  AW+1  current occupancy

Behaviour:
- Reset (resetn=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, ds_wait=0.
  - Outputs: validD=0, instrD=0, pcD=0, adelD=0, is_in_delayslotD=0, count_o=0, push_ready_o=1.
- Storage is registered. The head outputs are combinational from the entry at rd_ptr, gated by count!=0.
- push_ready_o = (count < DEPTH). There is no same-cycle credit from a pop.
- acc = push_valid_i & push_ready_o & ~flush_i.
- deq = validD & ~stallD.
- Latency: a push accepted in cycle N is visible on validD/instrD in cycle N+1. There is no bypass.
- Pointers wrap modulo DEPTH. count range is 0..DEPTH.
- Normal case (no flush, no honoured redirect):
  - acc writes {pc, inst, adel, ds}, where ds=ds_wait. wr_ptr increments.
  - deq increments rd_ptr.
  - count += acc - deq.
  - If acc is set, ds_wait is cleared.
- flush_i has the highest priority.
  - Next cycle: count=0, pointers equal, ds_wait=0.
  - Any push in the flush cycle is dropped. Any redirect in the flush cycle is ignored.
- redirect_i is honoured only when deq=1. When stallD=1 or the buffer is empty, redirect_i is ignored (decode contract).
- Honoured redirect, with n = count before the cycle:
  - n>=2: keep only the entry at rd_ptr+1, with its ds bit set to 1. count=1. A push in the same cycle is dropped.
  - n==1 and acc: the pushed entry becomes the sole entry with ds=1. count=1, ds_wait=0.
  - n==1 and no acc: count=0, ds_wait=1.
- ds_wait=1: the next accepted push is stored with ds=1, then ds_wait clears.
  - Fetch is responsible for not returning wrong-path instructions after the delay slot.
- Full and empty boundaries:
  - A push while count==DEPTH is not accepted, because push_ready_o=0.
  - A simultaneous pop and push at count==DEPTH-1 keeps count unchanged.
  - A pop on empty is impossible, because validD=0.
- Reset asserted mid-operation clears everything immediately, including ds_wait.

Decomposition:
- Shared package/header entries: DEPTH default; entry field widths (PC 32, INST 32); NOP_INST = 32'h0.
- Entry record {pc, inst, adel, ds} = 66 bits.
- One sub-module is natural: fetch_buf_ram, a DEPTH x 66 register array with 1 write port and 2 combinational read ports (rd_ptr and rd_ptr+1).
- The control logic (pointers, count, ds_wait, redirect/flush priority) lives in inst_fetch_buffer.

Test Plan:
- Reset and fill: push PCs 0xBFC00000..0xBFC0000C on 4 consecutive cycles with stallD=1.
  - Required: count_o=4, push_ready_o=0.
  - Required: a 5th push is not accepted.
  - Required: validD=1, pcD=0xBFC00000.
- Streaming: push every cycle with stallD=0.
  - Required: validD rises 1 cycle after the first push.
  - Required: pcD advances by 4 each cycle; count_o stays 1.
- Redirect with delay slot present: buffer holds PCs 0x100,0x104,0x108; redirect_i=1 with deq.
  - Required: next cycle count_o=1, pcD=0x104, is_in_delayslotD=1.
  - Required: 0x108 is discarded.
- Redirect with delay slot absent: buffer holds only 0x100; redirect_i=1 with no push.
  - Required: count_o=0, ds_wait=1.
  - Then push 0x104: required pcD=0x104, is_in_delayslotD=1.
  - Then push 0x200: required is_in_delayslotD=0 for that entry.
- Flush priority: flush_i=1 together with redirect_i=1 and push_valid_i=1 at count=3.
  - Required: next cycle count_o=0, validD=0, instrD=0.
  - Required: no delay-slot marking on later pushes.
- Address error and stall: push with push_adel_i=1, stallD=1 for 3 cycles.
  - Required: adelD=1 and pcD held stable throughout.
- Async reset pulsed mid-stream: required that all outputs return to reset values without waiting for a clock edge.
